// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Memory-side responder for a byte-wide CPU bus. Each enabled access is
//   decoded to either a single-port byte RAM or a small I/O window. The I/O
//   window connects a TX FIFO and an RX FIFO to an external byte-stream
//   peripheral through valid/ready handshakes.
//
// Ports
//   clk_in       system clock, rising edge
//   rst_in       asynchronous active-low reset
//   rdy_in       bus enable; no CPU access while low
//   cpu_a        byte address (bit RAM_AW selects I/O, low bits decoded)
//   cpu_wr       1 = write, 0 = read
//   cpu_wdata    write byte
//   cpu_rdata    registered read byte, valid one cycle after the address
//   io_tx_data   TX FIFO head byte (unregistered)
//   io_tx_valid  TX FIFO not empty
//   io_tx_ready  peripheral accepts io_tx_data
//   io_rx_data   byte from peripheral
//   io_rx_valid  io_rx_data valid
//   io_rx_ready  RX FIFO not full
//
// I/O map (offset = cpu_a[2:0]):
//   0 : write pushes TX, read pops RX (0x00 when empty)
//   4 : read status {5'b0, tx_ovf, tx_full, rx_nonempty}; write bit2 clears tx_ovf
module mem_io_responder #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  // ---------------- decode ----------------
  logic       ram_acc, io_acc;
  logic [2:0] io_off;

  assign ram_acc = rdy_in & ~cpu_a[RAM_AW];
  assign io_acc  = rdy_in &  cpu_a[RAM_AW];
  assign io_off  = cpu_a[2:0];

  // ---------------- RAM ----------------
  logic [7:0] ram [0:(1<<RAM_AW)-1];
  logic [7:0] ram_rdata_q;

  // Contents survive reset, so this block has no reset branch.
  always_ff @(posedge clk_in) begin
    if (ram_acc) begin
      if (cpu_wr) ram[cpu_a[RAM_AW-1:0]] <= cpu_wdata;
      else        ram_rdata_q            <= ram[cpu_a[RAM_AW-1:0]];
    end
  end

  // ---------------- FIFO state ----------------
  logic [7:0]         tx_mem [0:DEPTH-1];
  logic [7:0]         rx_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [FIFO_AW-1:0] tx_wr_d, tx_rd_d, rx_wr_d, rx_rd_d;
  logic [FIFO_AW:0]   tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
  logic               tx_ovf_q, tx_ovf_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_wr_req, rx_rd_req;

  // All full/empty decisions look only at the counts registered at the
  // start of the cycle, never at same-cycle pushes or pops.
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_wr_req = io_acc &  cpu_wr & (io_off == 3'd0);
  assign rx_rd_req = io_acc & ~cpu_wr & (io_off == 3'd0);

  assign tx_push = tx_wr_req & ~tx_full;
  assign tx_pop  = io_tx_valid & io_tx_ready;
  assign rx_push = io_rx_valid & io_rx_ready;
  assign rx_pop  = rx_rd_req & ~rx_empty;

  assign io_tx_valid = ~tx_empty;
  assign io_rx_ready = ~rx_full;
  assign io_tx_data  = tx_mem[tx_rd_q];

  always_comb begin
    tx_wr_d  = tx_wr_q + FIFO_AW'(tx_push);
    tx_rd_d  = tx_rd_q + FIFO_AW'(tx_pop);
    rx_wr_d  = rx_wr_q + FIFO_AW'(rx_push);
    rx_rd_d  = rx_rd_q + FIFO_AW'(rx_pop);
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    // Set and clear use different offsets, so they never collide.
    tx_ovf_d = tx_ovf_q;
    if (tx_wr_req && tx_full) tx_ovf_d = 1'b1;
    if (io_acc && cpu_wr && io_off == 3'd4 && cpu_wdata[2]) tx_ovf_d = 1'b0;
  end

  // FIFO storage is not reset; the pointers and counts define validity.
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_q] <= cpu_wdata;
    if (rx_push) rx_mem[rx_wr_q] <= io_rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  // ---------------- read data path ----------------
  logic [7:0] io_rdata_d, io_rdata_q;
  logic       rd_sel_ram_q;

  always_comb begin
    io_rdata_d = 8'h00;
    case (io_off)
      3'd0:    io_rdata_d = rx_empty ? 8'h00 : rx_mem[rx_rd_q];
      3'd4:    io_rdata_d = {5'b0, tx_ovf_q, tx_full, ~rx_empty};
      default: io_rdata_d = 8'h00;
    endcase
  end

  // The RAM read register cannot be reset (it belongs to the RAM), so the
  // visible read byte is a mux steered by a resettable source flag. Resetting
  // the flag to "I/O" together with io_rdata_q yields 0x00 during reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      io_rdata_q   <= 8'h00;
      rd_sel_ram_q <= 1'b0;
    end else if (io_acc && !cpu_wr) begin
      io_rdata_q   <= io_rdata_d;
      rd_sel_ram_q <= 1'b0;
    end else if (ram_acc && !cpu_wr) begin
      rd_sel_ram_q <= 1'b1;
    end
  end

  assign cpu_rdata = rd_sel_ram_q ? ram_rdata_q : io_rdata_q;

endmodule
